// File: rtl/lut_spram_loader.sv
// lut_spram_loader
//   Runtime writer for the voice-transform LUT SPRAM. A host byte stream is
//   packed into DATA_WIDTH-bit words and written to addresses 0..2^ADDR_WIDTH-1.
//   Outside a load the voice path reads through the same single RAM port.
//
//   Optional feature: define LUT_LOADER_CSUM_EN to append a checksum byte
//   (XOR of every data byte of the load) that is checked before done.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   load_start, load_abort  start pulse (IDLE only) / abort level
//   s_byte/s_valid/s_ready  host byte stream
//   user_addr/user_rd_en    voice-path read request (honoured in IDLE)
//   user_rd_valid/_data     read response, one cycle after the request
//   ram_*                   SPRAM port
//   busy, done, err         status: load active, success pulse, sticky error
module lut_spram_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic                  load_abort,
   input  logic [7:0]            s_byte,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [ADDR_WIDTH-1:0] user_addr,
   input  logic                  user_rd_en,
   output logic                  user_rd_valid,
   output logic [DATA_WIDTH-1:0] user_rd_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_wr_en,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {IDLE, RECV, WRITE, CSUM, FINISH} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] word_cnt;
   logic [BCW-1:0]        byte_cnt;
   logic [DATA_WIDTH-1:0] asm_q, asm_next;
   logic                  wr_en_q, done_q, err_q, rd_valid_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic                  accept;
`ifdef LUT_LOADER_CSUM_EN
   logic [7:0]            csum_q;
`endif

   assign accept = s_valid & s_ready;

   // Byte packing: MSB-first shifts left so the first byte ends up on top;
   // LSB-first shifts right so the first byte ends up in [7:0].
   always_comb begin
      asm_next = asm_q;
      if (MSB_FIRST) asm_next = (asm_q << 8) | DATA_WIDTH'(s_byte);
      else           asm_next = (asm_q >> 8) | (DATA_WIDTH'(s_byte) << (DATA_WIDTH - 8));
   end

   assign s_ready       = (state == RECV) || (state == CSUM);
   assign busy          = (state != IDLE);
   assign ram_addr      = busy ? word_cnt : user_addr;
   assign ram_wr_en     = wr_en_q;
   assign ram_wr_data   = wr_data_q;
   assign user_rd_valid = rd_valid_q;
   assign user_rd_data  = ram_rd_data;
   assign done          = done_q;
   assign err           = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_cnt   <= '0;
         byte_cnt   <= '0;
         asm_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
`ifdef LUT_LOADER_CSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         wr_en_q    <= 1'b0;
         done_q     <= 1'b0;
         // A request in the last IDLE cycle still returns: the RAM port is
         // still on user_addr at that edge.
         rd_valid_q <= (state == IDLE) && user_rd_en;
         case (state)
            IDLE: begin
               // Abort wins over a coincident start; err is left alone.
               if (load_start && !load_abort) begin
                  err_q    <= 1'b0;
                  word_cnt <= '0;
                  byte_cnt <= '0;
`ifdef LUT_LOADER_CSUM_EN
                  csum_q   <= '0;
`endif
                  state    <= RECV;
               end
            end
            RECV: begin
               if (load_abort) begin
                  err_q    <= 1'b1;
                  byte_cnt <= '0;
                  state    <= IDLE;
               end else if (accept) begin
                  asm_q <= asm_next;
`ifdef LUT_LOADER_CSUM_EN
                  csum_q <= csum_q ^ s_byte;
`endif
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt  <= '0;
                     wr_en_q   <= 1'b1;
                     wr_data_q <= asm_next;
                     state     <= WRITE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            WRITE: begin
               // The write strobe is already on the port this cycle, so an
               // abort here lets it land and stops everything after it.
               if (load_abort) begin
                  err_q <= 1'b1;
                  state <= IDLE;
               end else if (word_cnt == LAST_ADDR) begin
                  word_cnt <= '0;
`ifdef LUT_LOADER_CSUM_EN
                  state    <= CSUM;
`else
                  done_q   <= 1'b1;
                  state    <= FINISH;
`endif
               end else begin
                  word_cnt <= word_cnt + 1'b1;
                  state    <= RECV;
               end
            end
`ifdef LUT_LOADER_CSUM_EN
            CSUM: begin
               if (load_abort) begin
                  err_q <= 1'b1;
                  state <= IDLE;
               end else if (accept) begin
                  if (s_byte == csum_q) begin
                     done_q <= 1'b1;
                     state  <= FINISH;
                  end else begin
                     err_q <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
`endif
            // done is already on the wire here; the load has succeeded, so a
            // late abort has nothing left to stop.
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lut_spram_loader.sv
// tb_lut_spram_loader
//   Randomized bench for lut_spram_loader with a behavioural SPRAM, a
//   reference memory image and a write/done monitor. A second instance with
//   MSB_FIRST=0 checks little-endian packing.
module tb_lut_spram_loader;

   localparam int AW = 10;
   localparam int DW = 16;
   localparam int N  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_start, load_abort;
   logic [7:0]    s_byte;
   logic          s_valid, s_ready;
   logic [AW-1:0] user_addr;
   logic          user_rd_en, user_rd_valid;
   logic [DW-1:0] user_rd_data;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wr_data, ram_rd_data;
   logic          ram_wr_en, busy, done, err;

   // little-endian instance
   logic          l_start, l_abort, l_s_valid, l_s_ready, l_rd_en, l_rd_valid;
   logic [7:0]    l_s_byte;
   logic [AW-1:0] l_user_addr, l_ram_addr;
   logic [DW-1:0] l_rd_data, l_wr_data, l_ram_rd_data;
   logic          l_wr_en, l_busy, l_done, l_err;

   always #5 clk = ~clk;

   lut_spram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
      .s_byte(s_byte), .s_valid(s_valid), .s_ready(s_ready),
      .user_addr(user_addr), .user_rd_en(user_rd_en),
      .user_rd_valid(user_rd_valid), .user_rd_data(user_rd_data),
      .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
      .ram_rd_data(ram_rd_data), .busy(busy), .done(done), .err(err));

   lut_spram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst_n(rst_n), .load_start(l_start), .load_abort(l_abort),
      .s_byte(l_s_byte), .s_valid(l_s_valid), .s_ready(l_s_ready),
      .user_addr(l_user_addr), .user_rd_en(l_rd_en),
      .user_rd_valid(l_rd_valid), .user_rd_data(l_rd_data),
      .ram_addr(l_ram_addr), .ram_wr_data(l_wr_data), .ram_wr_en(l_wr_en),
      .ram_rd_data(l_ram_rd_data), .busy(l_busy), .done(l_done), .err(l_err));

   // behavioural SPRAM: synchronous read, one cycle latency
   logic [DW-1:0] mem [N];
   logic [DW-1:0] rd_q;
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
      rd_q <= mem[ram_addr];
   end
   assign ram_rd_data = rd_q;

   logic [DW-1:0] ref_mem  [N];
   logic [DW-1:0] ld_words [N];

   int n_vec = 0;
   int n_err = 0;

   // monitor: record every write and done pulse
   logic [AW-1:0] wa_q [$];
   logic [DW-1:0] wd_q [$];
   int   done_cnt = 0, sready_bad = 0, rdv_bad = 0, l_wcnt = 0;
   logic busy_d = 1'b0;
   logic [DW-1:0] l_word = '0;
   logic [AW-1:0] l_waddr = '0;

   always @(negedge clk) begin
      if (ram_wr_en) begin
         wa_q.push_back(ram_addr);
         wd_q.push_back(ram_wr_data);
         if (s_ready) sready_bad <= sready_bad + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (busy && busy_d && user_rd_valid) rdv_bad <= rdv_bad + 1;
      busy_d <= busy;
      if (l_wr_en) begin
         l_wcnt  <= l_wcnt + 1;
         l_word  <= l_wr_data;
         l_waddr <= l_ram_addr;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok);
      bit acc;
      s_byte  = b;
      s_valid = 1'b1;
      ok      = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk); acc = s_ready;
         tick();
         if (acc) begin ok = 1'b1; break; end
      end
      s_valid = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_wr_en"},  ram_wr_en, 0);
      check({tag, "_busy"},   busy, 0);
      check({tag, "_done"},   done, 0);
      check({tag, "_err"},    err, 0);
      check({tag, "_sready"}, s_ready, 0);
      check({tag, "_rdv"},    user_rd_valid, 0);
      check({tag, "_wdata"},  ram_wr_data, 0);
      check({tag, "_addr"},   ram_addr, 0);
   endtask

   task automatic ram_cmp(input string tag);
      int bad = 0;
      for (int k = 0; k < N; k++) if (mem[k] !== ref_mem[k]) bad++;
      check({tag, "_ram"}, bad, 0);
   endtask

   task automatic rd_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
      user_addr  = a;
      user_rd_en = 1'b1;
      tick();
      user_rd_en = 1'b0;
      @(negedge clk);
      check({tag, "_vld"},  user_rd_valid, 1);
      check({tag, "_data"}, user_rd_data, exp);
      tick();
      check({tag, "_vld0"}, user_rd_valid, 0);
   endtask

   task automatic pulse_start();
      load_start = 1'b1; tick(); load_start = 1'b0;
   endtask

   // Full load of ld_words; reference outcome comes from the load rules.
   task automatic do_load(input int max_gap, input bit bad_csum, input bit mid_start,
                          input bit rd_hold, input string tag);
      int wb, db, bad, to;
      logic [7:0] cs, b;
      bit ok, all_ok, succ;
      wb = wa_q.size(); db = done_cnt; cs = '0; all_ok = 1'b1;
      user_addr  = AW'($urandom_range(0, N - 1));
      user_rd_en = rd_hold;
      pulse_start();
      check({tag, "_busy"}, busy, 1);
      check({tag, "_errclr"}, err, 0);
      for (int k = 0; k < N; k++) begin
         if (mid_start && k == 300) pulse_start();
         for (int j = 0; j < 2; j++) begin
            b = (j == 0) ? ld_words[k][15:8] : ld_words[k][7:0];
            send_byte(b, ok);
            cs ^= b;
            if (!ok) all_ok = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
         end
      end
`ifdef LUT_LOADER_CSUM_EN
      send_byte(bad_csum ? ~cs : cs, ok);
      if (!ok) all_ok = 1'b0;
      succ = !bad_csum;
`else
      succ = 1'b1;
`endif
      to = 0;
      while (busy && to < 50) begin tick(); to++; end
      user_rd_en = 1'b0;
      check({tag, "_finished"}, {31'd0, all_ok && !busy}, 1);
      check({tag, "_nwr"}, wa_q.size() - wb, N);
      bad = 0;
      for (int k = 0; k < N && wb + k < wa_q.size(); k++)
         if (wa_q[wb + k] !== AW'(k) || wd_q[wb + k] !== ld_words[k]) bad++;
      check({tag, "_wseq"}, bad, 0);
      check({tag, "_done"}, done_cnt - db, succ ? 1 : 0);
      check({tag, "_err"}, err, !succ);
      for (int k = 0; k < N; k++) ref_mem[k] = ld_words[k];
      ram_cmp(tag);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wb;
      bit ok;
      rst_n = 1'b0; load_start = 0; load_abort = 0; s_byte = 0; s_valid = 0;
      user_addr = '0; user_rd_en = 0;
      l_start = 0; l_abort = 0; l_s_byte = 0; l_s_valid = 0; l_user_addr = '0;
      l_rd_en = 0; l_ram_rd_data = '0;
      for (int k = 0; k < N; k++) begin
         mem[k] = DW'($urandom);
         ref_mem[k] = mem[k];
      end
      repeat (3) tick();
      chk_zero("rst");
      rst_n = 1'b1;
      tick();

      // full load, word k = FFFF-k, no gaps
      for (int k = 0; k < N; k++) ld_words[k] = 16'hFFFF - DW'(k);
      do_load(0, 1'b0, 1'b0, 1'b0, "full");
      rd_chk(AW'(5), 16'hFFFA, "rd5");
      for (int i = 0; i < 4; i++) begin
         int a = $urandom_range(0, N - 1);
         rd_chk(AW'(a), 16'hFFFF - DW'(a), "rdrnd");
      end

      // random data with stream gaps; word 0 pins byte order
      for (int k = 0; k < N; k++) ld_words[k] = DW'($urandom);
      ld_words[0] = 16'h1234;
      do_load(7, 1'b0, 1'b0, 1'b0, "stall");
      check("wr_sready", sready_bad, 0);
      rd_chk(AW'(0), 16'h1234, "rd0");

      // abort right after word 100 has been handed to the RAM
      for (int k = 0; k < N; k++) ld_words[k] = ~ref_mem[k];
      wb = wa_q.size();
      pulse_start();
      for (int k = 0; k <= 100; k++) begin
         send_byte(ld_words[k][15:8], ok);
         send_byte(ld_words[k][7:0], ok);
      end
      load_abort = 1'b1;           // this cycle is the WRITE of word 100
      tick();
      load_abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_err", err, 1);
      repeat (4) tick();
      check("abort_nwr", wa_q.size() - wb, 101);
      for (int k = 0; k <= 100; k++) ref_mem[k] = ld_words[k];
      check("abort_101_old", mem[101], ref_mem[101]);
      ram_cmp("abort");

      // start and abort together in IDLE: nothing starts, err stays set
      load_start = 1'b1; load_abort = 1'b1;
      tick();
      load_start = 1'b0; load_abort = 1'b0;
      check("sa_busy", busy, 0);
      check("sa_err", err, 1);

      // next load clears err; rd_en held high and a stray start mid-load
      for (int k = 0; k < N; k++) ld_words[k] = DW'($urandom);
      do_load(0, 1'b0, 1'b1, 1'b1, "rpt");
      check("rd_block", rdv_bad, 0);

      // reset in the middle of a load
      for (int k = 0; k < N; k++) ld_words[k] = DW'($urandom);
      pulse_start();
      for (int k = 0; k < 250; k++) begin
         send_byte(ld_words[k][15:8], ok);
         send_byte(ld_words[k][7:0], ok);
      end
      user_addr = '0;
      rst_n = 1'b0;
      #2;
      chk_zero("midrst");
      tick();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < N; k++) ld_words[k] = DW'($urandom);
      do_load(0, 1'b0, 1'b0, 1'b0, "postrst");

`ifdef LUT_LOADER_CSUM_EN
      for (int k = 0; k < N; k++) ld_words[k] = DW'($urandom);
      do_load(2, 1'b1, 1'b0, 1'b0, "badcs");
`endif

      // little-endian packing on the second instance
      l_start = 1'b1; tick(); l_start = 1'b0;
      l_s_byte = 8'h12; l_s_valid = 1'b1; tick();
      l_s_byte = 8'h34; tick();
      l_s_valid = 1'b0;
      tick(); tick();
      check("lsb_nwr", l_wcnt, 1);
      check("lsb_addr", l_waddr, 0);
      check("lsb_word", l_word, 16'h3412);
      l_abort = 1'b1; tick(); l_abort = 1'b0;
      check("lsb_abort_err", l_err, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lut_spram_loader.md
Name: lut_spram_loader

Overview:
Runtime writer for the 1024x16 single-port LUT SPRAM used by the voice-transform path. Receives a byte stream from the host link, assembles bytes into words, and writes them to consecutive RAM addresses from 0 up to 2^ADDR_WIDTH-1. Outside a load, it passes voice-path read requests straight through to the same RAM port, so a table can be replaced without a second port.

Parameters:
ADDR_WIDTH, 10, RAM address width; a load writes 2^ADDR_WIDTH words.
DATA_WIDTH, 16, RAM word width; must be a multiple of 8.
MSB_FIRST, 1, 1 = first byte received fills word[DATA_WIDTH-1 -: 8]; 0 = first byte fills word[7:0].

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  single-cycle pulse; starts a load, honoured only in IDLE
load_abort  in  1  level; stops an in-progress load
s_byte  in  8  stream byte
s_valid  in  1  stream byte valid
s_ready  out  1  loader accepts a byte (transfer = s_valid & s_ready)
user_addr  in  ADDR_WIDTH  read address from the voice path
user_rd_en  in  1  read request
user_rd_valid  out  1  user_rd_data valid
user_rd_data  out  DATA_WIDTH  read data, driven directly from ram_rd_data
ram_addr  out  ADDR_WIDTH  to SPRAM addr
ram_wr_data  out  DATA_WIDTH  to SPRAM wr_data
ram_wr_en  out  1  to SPRAM wr_en
ram_rd_data  in  DATA_WIDTH  from SPRAM rd_data (non-registered output, 1-cycle latency)
busy  out  1  load in progress (not IDLE)
done  out  1  one-cycle pulse when a load completes successfully
err  out  1  sticky; set by abort or checksum failure, cleared by the next accepted load_start

Behaviour:
- Reset values: all outputs 0; state IDLE; word_cnt=0; byte_cnt=0; assembly register=0.
- FSM states:
  - IDLE
    - Accepted load_start: clear err, word_cnt and byte_cnt; go to RECV.
  - RECV
    - s_ready=1.
    - Each accepted byte shifts into the assembly register per MSB_FIRST and increments byte_cnt.
    - On the DATA_WIDTH/8-th byte, go to WRITE and reset byte_cnt.
  - WRITE (exactly 1 cycle)
    - s_ready=0, ram_wr_en=1, ram_addr=word_cnt, ram_wr_data=assembled word.
    - If word_cnt == 2^ADDR_WIDTH-1, go to FINISH; otherwise increment word_cnt and go to RECV.
  - FINISH (1 cycle)
    - done=1, go to IDLE.
    - word_cnt returns to 0; it never wraps into a second pass.
- ram_wr_en, ram_wr_data and the write-time ram_addr are registered outputs.
- ram_addr is a combinational mux: user_addr in IDLE, word_cnt otherwise.
- Read path:
  - In IDLE, user_rd_en=1 produces user_rd_valid=1 exactly one cycle later, with user_rd_data = RAM contents at that user_addr.
  - In any state other than IDLE, user_rd_en is ignored and user_rd_valid=0.
  - A read issued in the last IDLE cycle before load start still returns valid.
- busy = (state != IDLE). busy rises the cycle after load_start and falls the cycle after FINISH.
- load_start while busy: ignored, no effect on counters.
- load_abort while busy:
  - Next state is IDLE and err is set.
  - A WRITE in progress in that cycle still completes; no further writes follow.
  - Partial bytes are discarded.
  - RAM contents are left partially updated.
- Simultaneous load_start and load_abort in IDLE: abort wins; the load does not start and err is unchanged.
- Reset mid-load: immediate return to IDLE, ram_wr_en=0 asynchronously. RAM contents are undefined only for the address being written.
- Byte gaps (s_valid=0) are allowed at any point; no timeout.

Optional Feature:
Macro LUT_LOADER_CSUM_EN.
- Defined:
  - A CSUM state is inserted between the last WRITE and FINISH, with s_ready=1.
  - One extra byte is accepted and compared with the XOR of every data byte received in this load.
  - Match: FINISH and done pulse. Mismatch: err=1, no done pulse, return to IDLE.
  - The RAM is already written either way.
- Not defined: no CSUM state and no extra byte; the last WRITE goes directly to FINISH.

Test Plan:
- Full load: 2048 bytes giving word k = 16'hFFFF-k, MSB_FIRST=1, s_valid always high → 1024 writes at addresses 0..1023, done pulses once, err=0. Readback of addr 5 returns 16'hFFFA one cycle after user_rd_en.
- Byte order: bytes 8'h12, 8'h34 with MSB_FIRST=1 → addr 0 written with 16'h1234. With MSB_FIRST=0 → 16'h3412.
- Stalls: random s_valid gaps up to 7 cycles → same RAM contents as the full-load case. s_ready=0 in every WRITE cycle.
- Read blocking and repeat start: user_rd_en held high during a load → user_rd_valid=0 throughout. load_start pulsed mid-load → word_cnt unchanged, single done pulse.
- Abort: load_abort after word 100 is written → busy falls the next cycle, err=1. Addrs 0..100 hold new data, addr 101 holds old data. The next load_start clears err.
- Reset and checksum:
  - rst_n low mid-load → all outputs 0, IDLE; a subsequent full load succeeds.
  - With LUT_LOADER_CSUM_EN and a wrong checksum byte → err=1, no done pulse.
